// File: rtl/control_pkg.sv
// Shared decode constants and the packed control word for the ID-stage decoder.
// No logic here. With CU_ILLEGAL_OPCODE_EN defined, the control word also carries illegal_op.
// Backpressure: none.
package control_pkg;

    localparam int OPCODE_W = 6;
    localparam int EXEC_W   = 4;

    localparam logic [OPCODE_W-1:0] OP_NOP  = 6'd0;
    localparam logic [OPCODE_W-1:0] OP_ADD  = 6'd1;
    localparam logic [OPCODE_W-1:0] OP_SUB  = 6'd3;
    localparam logic [OPCODE_W-1:0] OP_AND  = 6'd5;
    localparam logic [OPCODE_W-1:0] OP_OR   = 6'd6;
    localparam logic [OPCODE_W-1:0] OP_NOR  = 6'd7;
    localparam logic [OPCODE_W-1:0] OP_XOR  = 6'd8;
    localparam logic [OPCODE_W-1:0] OP_SLA  = 6'd9;
    localparam logic [OPCODE_W-1:0] OP_SLL  = 6'd10;
    localparam logic [OPCODE_W-1:0] OP_SRA  = 6'd11;
    localparam logic [OPCODE_W-1:0] OP_SRL  = 6'd12;
    localparam logic [OPCODE_W-1:0] OP_ADDI = 6'd32;
    localparam logic [OPCODE_W-1:0] OP_SUBI = 6'd33;
    localparam logic [OPCODE_W-1:0] OP_LD   = 6'd36;
    localparam logic [OPCODE_W-1:0] OP_ST   = 6'd37;
    localparam logic [OPCODE_W-1:0] OP_BEZ  = 6'd40;
    localparam logic [OPCODE_W-1:0] OP_BNE  = 6'd41;
    localparam logic [OPCODE_W-1:0] OP_JMP  = 6'd42;

    localparam logic [EXEC_W-1:0] EXE_ADD = 4'b0000;
    localparam logic [EXEC_W-1:0] EXE_SUB = 4'b0010;
    localparam logic [EXEC_W-1:0] EXE_AND = 4'b0100;
    localparam logic [EXEC_W-1:0] EXE_OR  = 4'b0101;
    localparam logic [EXEC_W-1:0] EXE_NOR = 4'b0110;
    localparam logic [EXEC_W-1:0] EXE_XOR = 4'b0111;
    localparam logic [EXEC_W-1:0] EXE_SHL = 4'b1000;
    localparam logic [EXEC_W-1:0] EXE_SRA = 4'b1001;
    localparam logic [EXEC_W-1:0] EXE_SRL = 4'b1010;

    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_BEZ  = 2'b01,
        BR_BNE  = 2'b10,
        BR_JMP  = 2'b11
    } branch_t;

    typedef struct packed {
        logic [EXEC_W-1:0] exec_command;
        logic              mem_read;
        logic              mem_write;
        logic              wb_enable;
        logic              is_immediate;
        branch_t           branch_type;
`ifdef CU_ILLEGAL_OPCODE_EN
        logic              illegal_op;
`endif
    } ctrl_word_t;

endpackage

// File: rtl/control_decoder.sv
// Opcode to control-word decode; unknown opcodes give an all-zero word.
// Latency: purely combinational. Sets illegal_op when CU_ILLEGAL_OPCODE_EN is defined.
// Backpressure: none.
module control_decoder
    import control_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode,
    output ctrl_word_t          ctrl_word
);

    // ALU-type ops write back; per-op fields are overridden below.
    always_comb begin
        ctrl_word = '0;
        case (opcode)
            OP_NOP: ctrl_word = '0;
            OP_ADD: begin ctrl_word.exec_command = EXE_ADD; ctrl_word.wb_enable = 1'b1; end
            OP_SUB: begin ctrl_word.exec_command = EXE_SUB; ctrl_word.wb_enable = 1'b1; end
            OP_AND: begin ctrl_word.exec_command = EXE_AND; ctrl_word.wb_enable = 1'b1; end
            OP_OR:  begin ctrl_word.exec_command = EXE_OR;  ctrl_word.wb_enable = 1'b1; end
            OP_NOR: begin ctrl_word.exec_command = EXE_NOR; ctrl_word.wb_enable = 1'b1; end
            OP_XOR: begin ctrl_word.exec_command = EXE_XOR; ctrl_word.wb_enable = 1'b1; end
            OP_SLA: begin ctrl_word.exec_command = EXE_SHL; ctrl_word.wb_enable = 1'b1; end
            OP_SLL: begin ctrl_word.exec_command = EXE_SHL; ctrl_word.wb_enable = 1'b1; end
            OP_SRA: begin ctrl_word.exec_command = EXE_SRA; ctrl_word.wb_enable = 1'b1; end
            OP_SRL: begin ctrl_word.exec_command = EXE_SRL; ctrl_word.wb_enable = 1'b1; end
            OP_ADDI: begin
                ctrl_word.exec_command = EXE_ADD;
                ctrl_word.wb_enable    = 1'b1;
                ctrl_word.is_immediate = 1'b1;
            end
            OP_SUBI: begin
                ctrl_word.exec_command = EXE_SUB;
                ctrl_word.wb_enable    = 1'b1;
                ctrl_word.is_immediate = 1'b1;
            end
            OP_LD: begin
                ctrl_word.exec_command = EXE_ADD;
                ctrl_word.wb_enable    = 1'b1;
                ctrl_word.mem_read     = 1'b1;
                ctrl_word.is_immediate = 1'b1;
            end
            OP_ST: begin
                ctrl_word.exec_command = EXE_ADD;
                ctrl_word.mem_write    = 1'b1;
                ctrl_word.is_immediate = 1'b1;
            end
            OP_BEZ: ctrl_word.branch_type = BR_BEZ;
            OP_BNE: ctrl_word.branch_type = BR_BNE;
            OP_JMP: begin
                ctrl_word.branch_type  = BR_JMP;
                ctrl_word.is_immediate = 1'b1;
            end
            default: begin
                ctrl_word = '0;
`ifdef CU_ILLEGAL_OPCODE_EN
                ctrl_word.illegal_op = 1'b1;
`endif
            end
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// ID-stage main decoder: decoded control word with flush-to-NOP, registered for ID/EX.
// Latency: one clk from opcode to outputs; rst clears outputs asynchronously.
// Backpressure: none. Adds illegal_op output when CU_ILLEGAL_OPCODE_EN is defined.
module control_unit
    import control_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int EXEC_W   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                flush,
    output logic [EXEC_W-1:0]   exec_command,
    output logic                mem_read,
    output logic                mem_write,
    output logic                wb_enable,
    output logic                is_immediate,
`ifdef CU_ILLEGAL_OPCODE_EN
    output logic                illegal_op,
`endif
    output logic [1:0]          branch_type
);

    ctrl_word_t dec_word;
    ctrl_word_t ctrl_d;
    ctrl_word_t ctrl_q;

    control_decoder u_decoder (
        .opcode    (opcode),
        .ctrl_word (dec_word)
    );

    always_comb begin
        ctrl_d = '0;
        if (!flush) begin
            ctrl_d = dec_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign exec_command = ctrl_q.exec_command;
    assign mem_read     = ctrl_q.mem_read;
    assign mem_write    = ctrl_q.mem_write;
    assign wb_enable    = ctrl_q.wb_enable;
    assign is_immediate = ctrl_q.is_immediate;
    assign branch_type  = ctrl_q.branch_type;
`ifdef CU_ILLEGAL_OPCODE_EN
    assign illegal_op   = ctrl_q.illegal_op;
`endif

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit; covers both builds of CU_ILLEGAL_OPCODE_EN.
// Expected words are {exec_command, mem_read, mem_write, wb_enable, is_immediate, branch_type}.
module tb_control_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       flush;
    logic [3:0] exec_command;
    logic       mem_read;
    logic       mem_write;
    logic       wb_enable;
    logic       is_immediate;
    logic [1:0] branch_type;
`ifdef CU_ILLEGAL_OPCODE_EN
    logic       illegal_op;
`endif

    int checks   = 0;
    int failures = 0;

    control_unit dut (
        .clk          (clk),
        .rst          (rst),
        .opcode       (opcode),
        .flush        (flush),
        .exec_command (exec_command),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .wb_enable    (wb_enable),
        .is_immediate (is_immediate),
`ifdef CU_ILLEGAL_OPCODE_EN
        .illegal_op   (illegal_op),
`endif
        .branch_type  (branch_type)
    );

    always #5 clk = ~clk;

    logic [9:0] obs;
    assign obs = {exec_command, mem_read, mem_write, wb_enable, is_immediate, branch_type};

    localparam int NVEC = 22;
    logic [5:0] vec_op  [NVEC] = '{6'd0, 6'd1, 6'd3, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'd10, 6'd11,
                                   6'd12, 6'd32, 6'd33, 6'd36, 6'd37, 6'd40, 6'd41, 6'd42,
                                   6'd2, 6'd13, 6'd34, 6'd63};
    logic [9:0] vec_exp [NVEC] = '{10'b0000_0_0_0_0_00, 10'b0000_0_0_1_0_00, 10'b0010_0_0_1_0_00,
                                   10'b0100_0_0_1_0_00, 10'b0101_0_0_1_0_00, 10'b0110_0_0_1_0_00,
                                   10'b0111_0_0_1_0_00, 10'b1000_0_0_1_0_00, 10'b1000_0_0_1_0_00,
                                   10'b1001_0_0_1_0_00, 10'b1010_0_0_1_0_00, 10'b0000_0_0_1_1_00,
                                   10'b0010_0_0_1_1_00, 10'b0000_1_0_1_1_00, 10'b0000_0_1_0_1_00,
                                   10'b0000_0_0_0_0_01, 10'b0000_0_0_0_0_10, 10'b0000_0_0_0_1_11,
                                   10'b0, 10'b0, 10'b0, 10'b0};
    logic       vec_ill [NVEC] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                   1'b1, 1'b1, 1'b1, 1'b1};

    task automatic check(input string tag, input logic [9:0] exp, input logic exp_ill);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
`ifdef CU_ILLEGAL_OPCODE_EN
        checks++;
        assert (illegal_op === exp_ill) else begin
            failures++;
            $error("FAIL %s illegal_op: observed=%b expected=%b", tag, illegal_op, exp_ill);
        end
`else
        // Unknown opcodes must look exactly like NOP in the default build.
        if (exp_ill) begin
            checks++;
            assert (obs === 10'b0) else begin
                failures++;
                $error("FAIL %s unknown-as-nop: observed=%b expected=%b", tag, obs, 10'b0);
            end
        end
`endif
    endtask

    task automatic step(input logic [5:0] op, input logic fl);
        @(negedge clk);
        opcode = op;
        flush  = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst    = 1'b1;
        opcode = 6'b000001;
        flush  = 1'b0;
        #1;
        check("reset_t0", 10'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_held", 10'b0, 1'b0);

        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("add_after_reset", 10'b0000_0_0_1_0_00, 1'b0);

        step(6'b100000, 1'b0); check("addi",  10'b0000_0_0_1_1_00, 1'b0);
        step(6'b000001, 1'b0); check("add",   10'b0000_0_0_1_0_00, 1'b0);
        step(6'b100001, 1'b0); check("subi",  10'b0010_0_0_1_1_00, 1'b0);
        step(6'b100101, 1'b0); check("st",    10'b0000_0_1_0_1_00, 1'b0);
        step(6'b000010, 1'b0); check("undef2", 10'b0, 1'b1);
        step(6'b101001, 1'b0); check("bne",   10'b0000_0_0_0_0_10, 1'b0);

        for (int i = 0; i < NVEC; i++) begin
            step(vec_op[i], 1'b0);
            check($sformatf("table_op%0d", vec_op[i]), vec_exp[i], vec_ill[i]);
        end

        step(6'b100100, 1'b1); check("ld_flushed", 10'b0, 1'b0);
        step(6'b100100, 1'b0); check("ld",         10'b0000_1_0_1_1_00, 1'b0);
        step(6'b000010, 1'b1); check("undef_flushed", 10'b0, 1'b0);

        step(6'b101010, 1'b0); check("jmp", 10'b0000_0_0_0_1_11, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_midcycle", 10'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        step(6'bxxxxxx, 1'b0);
        step(6'b000011, 1'b0); check("sub_after_x", 10'b0010_0_0_1_0_00, 1'b0);
        step(6'b101000, 1'b0); check("bez",         10'b0000_0_0_0_0_01, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Main decoder for the multicycle MIPS-style datapath in the ID stage.
- Maps a 6-bit instruction opcode to ALU execute command, memory read/write strobes, write-back enable, immediate-operand select and branch type.
- Outputs are registered, one cycle after the opcode is sampled, and feed the ID/EX pipeline register.

Parameters:
- OPCODE_W, 6, opcode width; fixed, must be 6.
- EXEC_W, 4, execute-command width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- opcode  input  6  instruction bits [31:26].
- flush  input  1  synchronous; when 1, next registered outputs are NOP (all zero).
- exec_command  output  4  ALU operation code.
- mem_read  output  1  load strobe.
- mem_write  output  1  store strobe.
- wb_enable  output  1  register-file write enable.
- is_immediate  output  1  ALU operand B = sign-extended immediate.
- branch_type  output  2  00 none, 01 BEZ, 10 BNE, 11 JMP.

Behaviour:
- Reset: while rst=1 all outputs are 0, asynchronously. Release of reset is synchronous to clk.
- Latency: outputs update on each rising clk from the current opcode. Combinational decode feeds one register stage.
- flush=1 overrides decode and loads all-zero outputs (NOP).
- Decode table, as opcode (decimal): exec_command, wb, mem_read, mem_write, imm, branch_type:
  - 0 NOP: 0000, 0, 0, 0, 0, 00.
  - 1 ADD: 0000, 1, 0, 0, 0, 00.
  - 3 SUB: 0010, 1, 0, 0, 0, 00.
  - 5 AND: 0100, 1, 0, 0, 0, 00.
  - 6 OR: 0101, 1, 0, 0, 0, 00.
  - 7 NOR: 0110, 1, 0, 0, 0, 00.
  - 8 XOR: 0111, 1, 0, 0, 0, 00.
  - 9 SLA: 1000, 1, 0, 0, 0, 00.
  - 10 SLL: 1000, 1, 0, 0, 0, 00.
  - 11 SRA: 1001, 1, 0, 0, 0, 00.
  - 12 SRL: 1010, 1, 0, 0, 0, 00.
  - 32 ADDI: 0000, 1, 0, 0, 1, 00.
  - 33 SUBI: 0010, 1, 0, 0, 1, 00.
  - 36 LD: 0000, 1, 1, 0, 1, 00.
  - 37 ST: 0000, 0, 0, 1, 1, 00.
  - 40 BEZ: 0000, 0, 0, 0, 0, 01.
  - 41 BNE: 0000, 0, 0, 0, 0, 10.
  - 42 JMP: 0000, 0, 0, 0, 1, 11.
- Any other opcode (e.g. 2, 4, 13–31, 34, 35, 38, 39, 43–63) decodes as NOP: all outputs 0.
- Invariants:
  - mem_read and mem_write are never both 1.
  - mem_write=1 implies wb_enable=0.
  - branch_type≠00 implies wb_enable=0.
- X/Z on opcode: outputs are don't-care; no X propagation after the next valid opcode.
- rst asserted mid-operation clears outputs immediately, regardless of flush or opcode.

Optional Feature:
- Macro CU_ILLEGAL_OPCODE_EN.
- Defined:
  - Adds output illegal_op (1 bit), registered with the other outputs.
  - illegal_op = 1 for any opcode outside the decode table; reset value 0; forced 0 by flush.
- Not defined:
  - Port absent; unknown opcodes silently decode as NOP.
  - All other behaviour is identical in both builds.

Decomposition:
- Package control_pkg holds:
  - opcode localparams (OP_NOP … OP_JMP);
  - exec-command constants (EXE_ADD=0000, EXE_SUB=0010, EXE_AND=0100, EXE_OR=0101, EXE_NOR=0110, EXE_XOR=0111, EXE_SHL=1000, EXE_SRA=1001, EXE_SRL=1010);
  - branch-type constants (BR_NONE, BR_BEZ, BR_BNE, BR_JMP);
  - packed control-word typedef.
- One natural sub-module, control_decoder: purely combinational opcode → control word.
- control_unit wraps the decoder with the flush mux and the reset register.

Test Plan:
- Reset: rst=1 with opcode=6'b000001 → all outputs 0 across clock edges; deassert → next edge gives ADD decode.
- opcode=6'b100000 (ADDI) → after one clk: exec_command=0000, wb_enable=1, is_immediate=1, mem_read=0, mem_write=0, branch_type=00.
- opcode=6'b000001 (ADD) → exec_command=0000, wb_enable=1, is_immediate=0, branch_type=00.
- opcode=6'b100001 (SUBI), then 6'b100101 (ST) →
  - SUBI: exec_command=0010, wb=1, imm=1.
  - ST: mem_write=1, wb=0, imm=1.
- opcode=6'b000010 (undefined), then 6'b101001 (BNE) →
  - undefined: all zeros (illegal_op=1 when CU_ILLEGAL_OPCODE_EN).
  - BNE: branch_type=10, wb=0.
- opcode=6'b100100 (LD) with flush=1 for one cycle, then flush=0 → outputs zero that cycle; next edge mem_read=1, wb=1, imm=1. Assert rst mid-cycle → outputs 0 without waiting for clk.
